// File: rtl/writeback_unit.sv
// writeback_unit
// Producer side of the general-purpose register file write port. It merges
// the single-cycle ALU result stream and the long-latency memory/load result
// stream into one registered write per cycle. It also keeps a scoreboard of
// registers still waiting on a load, so issue logic can stall on them, and it
// flags when a decoded source register matches the write currently on the port.

module writeback_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    // Long-latency op issue (reserves a destination register)
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,

    // Single-cycle ALU results (never stalled)
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,

    // Memory/load results (held upstream until accepted)
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,

    // Decode-stage hazard and forwarding queries
    input  logic [ADDR_WIDTH-1:0] src_a,
    input  logic [ADDR_WIDTH-1:0] src_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,

    // Register file write port (committed on the falling edge)
    output logic [DATA_WIDTH-1:0] wb_data_d,
    output logic [ADDR_WIDTH-1:0] wb_addres_d,
    output logic                  wb_enable,

    // Sticky scoreboard error
    output logic                  sb_conflict
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Registered write port state
    logic                  wbEnable_q;
    logic                  wbEnable_d;
    logic [DATA_WIDTH-1:0] wbData_q;
    logic [DATA_WIDTH-1:0] wbData_d;
    logic [ADDR_WIDTH-1:0] wbAddr_q;
    logic [ADDR_WIDTH-1:0] wbAddr_d;

    // Pending-load scoreboard; bit 0 is kept permanently clear
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    // Sticky double-issue error
    logic                  conflict_q;
    logic                  conflict_d;

    // Per-cycle decisions
    logic                  memAccept;
    logic                  memXfer;
    logic                  issueTakes;
    logic                  issueClearedSameCycle;
    logic                  winValid;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic [DATA_WIDTH-1:0] winData;

    // ALU always wins the port; memory only moves when the ALU is idle and we are not in reset
    always_comb begin
        memAccept             = !alu_valid && !rst;
        memXfer               = mem_valid && memAccept;
        issueTakes            = issue_valid && (issue_addr != '0);
        issueClearedSameCycle = memXfer && (mem_addr == issue_addr);
    end

    // Pick the result that owns the write port this cycle
    always_comb begin
        winValid = 1'b0;
        winAddr  = alu_addr;
        winData  = alu_data;
        if (alu_valid) begin
            winValid = 1'b1;
            winAddr  = alu_addr;
            winData  = alu_data;
        end else if (memXfer) begin
            winValid = 1'b1;
            winAddr  = mem_addr;
            winData  = mem_data;
        end
    end

    // Next write-port contents; r0 writes still move data/address but never enable the write
    always_comb begin
        wbEnable_d = winValid && (winAddr != '0);
        wbData_d   = wbData_q;
        wbAddr_d   = wbAddr_q;
        if (winValid) begin
            wbData_d = winData;
            wbAddr_d = winAddr;
        end
    end

    // Scoreboard update: completion clears first, then a same-cycle issue re-sets the bit
    always_comb begin
        pending_d = pending_q;
        if (memXfer) begin
            pending_d[mem_addr] = 1'b0;
        end
        if (issueTakes) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // A second issue to a register whose load has not returned latches the error flag
    always_comb begin
        conflict_d = conflict_q;
        if (issueTakes && pending_q[issue_addr] && !issueClearedSameCycle) begin
            conflict_d = 1'b1;
        end
    end

    // All state updates with a synchronous reset that overrides any same-cycle activity
    always_ff @(posedge clk) begin
        if (rst) begin
            wbEnable_q <= 1'b0;
            wbData_q   <= '0;
            wbAddr_q   <= '0;
            pending_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            wbEnable_q <= wbEnable_d;
            wbData_q   <= wbData_d;
            wbAddr_q   <= wbAddr_d;
            pending_q  <= pending_d;
            conflict_q <= conflict_d;
        end
    end

    // Hazard and forwarding queries, combinational from registered state
    always_comb begin
        busy_a    = (src_a != '0) && pending_q[src_a];
        busy_b    = (src_b != '0) && pending_q[src_b];
        fwd_hit_a = wbEnable_q && (wbAddr_q == src_a) && (src_a != '0);
        fwd_hit_b = wbEnable_q && (wbAddr_q == src_b) && (src_b != '0);
    end

    assign mem_ready   = memAccept;
    assign wb_enable   = wbEnable_q;
    assign wb_data_d   = wbData_q;
    assign wb_addres_d = wbAddr_q;
    assign sb_conflict = conflict_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
// Directed bench for writeback_unit. A register-file-level model follows the
// behaviour from the outside (which result writes where, which registers await
// a load) and is compared against the DUT on every falling edge; directed
// literal expectations pin the model at key points of each scenario.

`timescale 1ns/100ps

module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        busy_a;
    logic        busy_b;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_addres_d;
    logic        wb_enable;
    logic        sb_conflict;

    int checks = 0;
    int errors = 0;

    writeback_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .fwd_hit_a   (fwd_hit_a),
        .fwd_hit_b   (fwd_hit_b),
        .wb_data_d   (wb_data_d),
        .wb_addres_d (wb_addres_d),
        .wb_enable   (wb_enable),
        .sb_conflict (sb_conflict)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every mismatch prints one FAIL line
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive all data-path inputs for the coming rising edge
    task automatic applyStimulus(input logic aluV, input logic [4:0] aluA, input logic [31:0] aluD,
                                 input logic memV, input logic [4:0] memA, input logic [31:0] memD,
                                 input logic issV, input logic [4:0] issA);
        alu_valid   = aluV;
        alu_addr    = aluA;
        alu_data    = aluD;
        mem_valid   = memV;
        mem_addr    = memA;
        mem_data    = memD;
        issue_valid = issV;
        issue_addr  = issA;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Register-file-level model: what the write port shows after each edge
    // and which registers are still waiting on a load.
    // ------------------------------------------------------------------
    bit          mValid = 1'b0;
    bit          mEn;
    logic [31:0] mData;
    logic [4:0]  mAddr;
    bit          mConflict;
    bit          mPend[32];

    function automatic bit expBusy(input logic [4:0] s);
        return (s != 0) && mPend[s];
    endfunction

    function automatic bit expFwd(input logic [4:0] s);
        return mEn && (mAddr == s) && (s != 0);
    endfunction

    // Compare on every falling edge, then fold in the inputs the next rising edge will see
    initial begin
        forever begin
            @(negedge clk);
            if (mValid) begin
                checkOutput("model wb_enable",   wb_enable,   mEn);
                checkOutput("model wb_data_d",   wb_data_d,   mData);
                checkOutput("model wb_addres_d", wb_addres_d, mAddr);
                checkOutput("model sb_conflict", sb_conflict, mConflict);
                checkOutput("model mem_ready",   mem_ready,   !alu_valid && !rst);
                checkOutput("model busy_a",      busy_a,      expBusy(src_a));
                checkOutput("model busy_b",      busy_b,      expBusy(src_b));
                checkOutput("model fwd_hit_a",   fwd_hit_a,   expFwd(src_a));
                checkOutput("model fwd_hit_b",   fwd_hit_b,   expFwd(src_b));
            end
            if (rst) begin
                mValid    = 1'b1;
                mEn       = 1'b0;
                mData     = 32'h0;
                mAddr     = 5'd0;
                mConflict = 1'b0;
                foreach (mPend[i]) mPend[i] = 1'b0;
            end else if (mValid) begin
                bit memTaken;
                memTaken = mem_valid && !alu_valid;
                if (alu_valid) begin
                    mEn   = (alu_addr != 0);
                    mData = alu_data;
                    mAddr = alu_addr;
                end else if (memTaken) begin
                    mEn   = (mem_addr != 0);
                    mData = mem_data;
                    mAddr = mem_addr;
                end else begin
                    mEn = 1'b0;
                end
                if (issue_valid && issue_addr != 0 && mPend[issue_addr]
                    && !(memTaken && mem_addr == issue_addr)) begin
                    mConflict = 1'b1;
                end
                if (memTaken) mPend[mem_addr] = 1'b0;
                if (issue_valid && issue_addr != 0) mPend[issue_addr] = 1'b1;
            end
        end
    end

    // Directed scenarios with hand-computed literal expectations
    initial begin
        rst   = 1'b1;
        src_a = 5'd0;
        src_b = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFE0003, 1'b1, 5'd9);

        // Reset held for two edges with memory and issue activity present
        tick();
        tick();
        checkOutput("reset wb_enable",   wb_enable,   1'b0);
        checkOutput("reset wb_data_d",   wb_data_d,   32'h0);
        checkOutput("reset wb_addres_d", wb_addres_d, 5'd0);
        checkOutput("reset mem_ready",   mem_ready,   1'b0);
        checkOutput("reset sb_conflict", sb_conflict, 1'b0);
        for (int i = 0; i < 32; i++) begin
            src_a = 5'(i);
            #0.1;
            checkOutput("reset busy_a", busy_a, 1'b0);
        end
        tick();
        rst = 1'b0;
        idle();
        src_a = 5'd0;
        tick();

        // ALU write to r5, visible one cycle later, then drops
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        src_a = 5'd5;
        tick();
        checkOutput("alu wb_enable",   wb_enable,   1'b1);
        checkOutput("alu wb_addres_d", wb_addres_d, 5'd5);
        checkOutput("alu wb_data_d",   wb_data_d,   32'hDEADBEEF);
        checkOutput("alu fwd_hit_a",   fwd_hit_a,   1'b1);
        idle();
        tick();
        checkOutput("alu idle wb_enable", wb_enable, 1'b0);
        checkOutput("alu idle data hold", wb_data_d, 32'hDEADBEEF);
        checkOutput("alu idle fwd_hit_a", fwd_hit_a, 1'b0);

        // Load to r7: issue marks it busy, completion clears it and writes
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        src_a = 5'd7;
        tick();
        checkOutput("load busy_a set", busy_a, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        #1;
        checkOutput("load mem_ready", mem_ready, 1'b1);
        tick();
        idle();
        #1;
        checkOutput("load busy_a clear", busy_a,      1'b0);
        checkOutput("load wb_enable",    wb_enable,   1'b1);
        checkOutput("load wb_addres_d",  wb_addres_d, 5'd7);
        checkOutput("load wb_data_d",    wb_data_d,   32'h12345678);
        tick();

        // Collision: ALU r3 and memory r9 in the same cycle
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        src_b = 5'd9;
        tick();
        applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0);
        #1;
        checkOutput("collide mem_ready", mem_ready, 1'b0);
        tick();
        checkOutput("collide wb_addres_d", wb_addres_d, 5'd3);
        checkOutput("collide wb_data_d",   wb_data_d,   32'h1);
        checkOutput("collide busy_b held", busy_b,      1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0);
        #1;
        checkOutput("collide mem_ready later", mem_ready, 1'b1);
        tick();
        idle();
        #1;
        checkOutput("collide mem wb_addres_d", wb_addres_d, 5'd9);
        checkOutput("collide mem wb_data_d",   wb_data_d,   32'h2);
        checkOutput("collide mem wb_enable",   wb_enable,   1'b1);
        checkOutput("collide busy_b clear",    busy_b,      1'b0);
        tick();

        // r0: ALU write suppressed, memory result accepted and discarded, issue ignored
        applyStimulus(1'b1, 5'd0, 32'hAAAA5555, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        src_a = 5'd0;
        tick();
        checkOutput("r0 alu wb_enable", wb_enable, 1'b0);
        checkOutput("r0 alu fwd_hit_a", fwd_hit_a, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h00000005, 1'b1, 5'd0);
        #1;
        checkOutput("r0 mem_ready", mem_ready, 1'b1);
        tick();
        idle();
        #1;
        checkOutput("r0 mem wb_enable", wb_enable, 1'b0);
        checkOutput("r0 mem wb_data_d", wb_data_d, 32'h00000005);
        checkOutput("r0 issue busy_a",  busy_a,    1'b0);

        // Same-cycle re-issue and completion of r4: set wins, no conflict
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        src_a = 5'd4;
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        tick();
        idle();
        #1;
        checkOutput("r4 busy_a kept",    busy_a,      1'b1);
        checkOutput("r4 sb_conflict",    sb_conflict, 1'b0);
        checkOutput("r4 wb_addres_d",    wb_addres_d, 5'd4);
        checkOutput("r4 fwd_hit_a",      fwd_hit_a,   1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("r4 busy_a clear", busy_a, 1'b0);

        // Double issue of r12 latches the sticky conflict until reset
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        src_a = 5'd12;
        tick();
        checkOutput("conflict first issue", sb_conflict, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("conflict set",      sb_conflict, 1'b1);
        checkOutput("conflict busy_a",   busy_a,      1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        tick();
        checkOutput("conflict sticky", sb_conflict, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("conflict reset",  sb_conflict, 1'b0);
        checkOutput("conflict reset busy", busy_a,  1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the general-purpose register file write port.
- Merges results from the single-cycle ALU path and the long-latency memory/load path into one registered write per cycle.
- Drives the register file's data, destination and write-enable inputs; the register file commits on the falling edge.
- Keeps a pending-write scoreboard so issue logic can stall on source registers still awaiting a load result, and flags same-cycle forwarding hits.

Parameters:
- DATA_WIDTH, 32, width of result data and write data.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- issue_valid  input  1  a long-latency op is issued this cycle.
- issue_addr  input  ADDR_WIDTH  destination register of the issued long-latency op.
- alu_valid  input  1  ALU result present this cycle; cannot be stalled.
- alu_addr  input  ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- mem_valid  input  1  memory result offered.
- mem_addr  input  ADDR_WIDTH  memory result destination register.
- mem_data  input  DATA_WIDTH  memory result.
- mem_ready  output  1  memory result accepted this cycle.
- src_a  input  ADDR_WIDTH  source register "a" of the instruction being decoded.
- src_b  input  ADDR_WIDTH  source register "b" of the instruction being decoded.
- busy_a  output  1  src_a has a pending long-latency write.
- busy_b  output  1  src_b has a pending long-latency write.
- fwd_hit_a  output  1  src_a equals the destination of the write currently on the port.
- fwd_hit_b  output  1  src_b equals the destination of the write currently on the port.
- wb_data_d  output  DATA_WIDTH  write data to the register file.
- wb_addres_d  output  ADDR_WIDTH  write address to the register file.
- wb_enable  output  1  write enable to the register file.
- sb_conflict  output  1  sticky error: issue to a register that is already pending.

Behaviour:

Reset (rst=1 at a rising edge):
- wb_enable=0, wb_data_d=0, wb_addres_d=0, sb_conflict=0.
- All 32 pending bits cleared.
- Reset overrides any same-cycle accept or issue; an in-flight memory result is dropped.

Arbitration:
- ALU has fixed priority.
- mem_ready = !alu_valid && !rst (combinational).
- A memory transfer occurs when mem_valid && mem_ready.

Output stage (registered, latency 1):
- At a rising edge, with W the winning source (ALU if alu_valid, else memory on a transfer):
  - wb_data_d <= W data; wb_addres_d <= W address.
  - wb_enable <= 1 only if W exists and its address != 0.
- Otherwise wb_enable <= 0, and wb_data_d / wb_addres_d hold their previous values.
- The register file commits on the following falling edge, so a result is readable from the register file 1.5 cycles after its source-valid cycle.

Register 0:
- A write to r0 never asserts wb_enable.
- A memory result to r0 is still accepted (mem_ready honoured) and is discarded.
- issue_addr=0 never sets a pending bit.

Scoreboard (pending[31:1]):
- Set: pending[issue_addr] on issue_valid when issue_addr != 0.
- Clear: pending[mem_addr] on a memory transfer.
- Set and clear of the same address in the same cycle: set wins.
- ALU writes never touch the scoreboard.
- Issue to an already-pending address (and not cleared in that same cycle) sets sb_conflict; it stays set until reset. The pending bit remains set.

Hazard and forwarding outputs:
- busy_a = (src_a != 0) && pending[src_a], combinational from registered state. Same rule for busy_b.
- fwd_hit_a = wb_enable && (wb_addres_d == src_a) && (src_a != 0). Same rule for fwd_hit_b.
- Forwarded data is wb_data_d; the consumer muxes it in.

No internal buffering:
- The unit holds no queue; the memory path holds its result until mem_ready.
- Back-to-back accepts are allowed every cycle.

Test Plan:
- Reset: assert rst for 2 cycles with mem_valid=1 and issue_valid=1 -> wb_enable=0, wb_data_d=0, wb_addres_d=0, mem_ready=0, busy_a=0 for every src_a, sb_conflict=0.
- ALU path: alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF in cycle N -> cycle N+1: wb_enable=1, wb_addres_d=5, wb_data_d=32'hDEADBEEF, fwd_hit_a=1 with src_a=5; cycle N+2 with alu_valid=0 -> wb_enable=0.
- Load scoreboard: issue_valid=1, issue_addr=7 -> next cycle busy_a=1 (src_a=7); mem_valid=1, mem_addr=7, mem_data=32'h12345678 -> accepted; next cycle busy_a=0, wb_enable=1, wb_addres_d=7, wb_data_d=32'h12345678.
- Collision: alu_valid=1 (r3, 32'h1) and mem_valid=1 (r9, 32'h2) in the same cycle -> mem_ready=0, r3 written next cycle; the following cycle with alu_valid=0 -> mem_ready=1, r9 written with 32'h2, and pending[9] clears.
- r0 and simultaneous events: alu_addr=0 -> wb_enable stays 0; mem to r0 accepted with wb_enable=0; issue_addr=4 and a memory completion to r4 in the same cycle while pending[4]=1 -> pending[4] remains 1, sb_conflict stays 0.
- Conflict: issue r12 twice with no completion in between -> sb_conflict=1 after the second issue, and it stays 1 until rst.
